// File: rtl/baby_ram_pkg.sv
// baby_ram shared constants, state encoding and storage width.
// Storage width grows by one bit when BABY_RAM_PARITY_EN is defined.
package baby_ram_pkg;

    localparam int WORDS_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int DATA_W    = 32;

`ifdef BABY_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/baby_ram_if.sv
// Requester-side bus of baby_ram: address, data, req/ack handshake.
// The master modport is the requester, the slave modport is the RAM.
interface baby_ram_if;
    import baby_ram_pkg::*;

    logic [31:0]       ram_addr_i;
    logic [DATA_W-1:0] ram_data_i;
    logic [DATA_W-1:0] ram_data_o;
    logic              req_i;
    logic              we_i;
    logic              ack_o;
    logic              addr_err_o;

    modport master (
        output ram_addr_i,
        output ram_data_i,
        output req_i,
        output we_i,
        input  ram_data_o,
        input  ack_o,
        input  addr_err_o
    );

    modport slave (
        input  ram_addr_i,
        input  ram_data_i,
        input  req_i,
        input  we_i,
        output ram_data_o,
        output ack_o,
        output addr_err_o
    );

endinterface

// File: rtl/baby_ram_array.sv
// Single-port storage: synchronous write, registered read.
// Width is chosen by the top (32, or 33 with a parity bit).
module baby_ram_array #(
    parameter int WORDS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Read register only loads when a read is issued, otherwise holds.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem[addr_i];
        end
    end

    // Array write port and read data register.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/baby_ram.sv
// baby_ram: 32x32 word RAM with req/ack access and zeroing sweep.
// Optional per-word parity via `define BABY_RAM_PARITY_EN.
module baby_ram
    import baby_ram_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic       ram_clk_i,
    input  logic       ram_rst_i,
    baby_ram_if.slave  bus,
`ifdef BABY_RAM_PARITY_EN
    input  logic       par_inject_i,
    output logic       par_err_o,
`endif
    input  logic       clear_i,
    output logic       busy_o
);

    state_e            state_d, state_q;
    logic [AW-1:0]     cnt_d, cnt_q;
    logic              busy_d, busy_q;
    logic              ack_d, ack_q;
    logic              err_d, err_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [AW-1:0]     idx_d, idx_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              we_d, we_q;
    logic              oor_d, oor_q;
`ifdef BABY_RAM_PARITY_EN
    logic              inj_d, inj_q;
    logic              perr_d, perr_q;
`endif

    logic [AW-1:0]     arr_addr;
    logic              arr_we;
    logic              arr_re;
    logic [MEM_W-1:0]  arr_wdata;
    logic [MEM_W-1:0]  arr_rdata;
    logic              in_oor;

    assign in_oor = |bus.ram_addr_i[31:AW];

    // Sequencer: sweep, request capture and response; drives the array port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        oor_d     = oor_q;
`ifdef BABY_RAM_PARITY_EN
        inj_d     = inj_q;
        perr_d    = perr_q;
`endif
        arr_addr  = idx_q;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_wdata = '0;

        unique case (state_q)
            ST_CLEAR: begin
                arr_addr = cnt_q;
                arr_we   = 1'b1;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == AW'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
`ifdef BABY_RAM_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            ST_IDLE: begin
                if (bus.req_i) begin
                    idx_d    = bus.ram_addr_i[AW-1:0];
                    oor_d    = in_oor;
                    we_d     = bus.we_i;
                    wdata_d  = bus.ram_data_i;
`ifdef BABY_RAM_PARITY_EN
                    inj_d    = par_inject_i;
`endif
                    // Read is issued now so data is ready in RESP.
                    arr_addr = bus.ram_addr_i[AW-1:0];
                    arr_re   = ~bus.we_i;
                    state_d  = ST_RESP;
                end else if (clear_i) begin
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_RESP: begin
                ack_d    = 1'b1;
                err_d    = oor_q;
                arr_we   = we_q & ~oor_q;
`ifdef BABY_RAM_PARITY_EN
                arr_wdata = {(^wdata_q) ^ inj_q, wdata_q};
                if (!we_q && !oor_q && (^arr_rdata)) begin
                    perr_d = 1'b1;
                end
`else
                arr_wdata = wdata_q;
`endif
                if (we_q) begin
                    data_d = wdata_q;
                end else if (oor_q) begin
                    data_d = '0;
                end else begin
                    data_d = arr_rdata[DATA_W-1:0];
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset restarts the sweep from word 0.
    always_ff @(posedge ram_clk_i) begin
        if (ram_rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
`ifdef BABY_RAM_PARITY_EN
            inj_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
`ifdef BABY_RAM_PARITY_EN
            inj_q   <= inj_d;
            perr_q  <= perr_d;
`endif
        end
    end

    baby_ram_array #(
        .WORDS (WORDS),
        .AW    (AW),
        .DW    (MEM_W)
    ) u_array (
        .clk_i   (ram_clk_i),
        .addr_i  (arr_addr),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    assign bus.ram_data_o = data_q;
    assign bus.ack_o      = ack_q;
    assign bus.addr_err_o = err_q;
    assign busy_o         = busy_q;
`ifdef BABY_RAM_PARITY_EN
    assign par_err_o      = perr_q;
`endif

endmodule

// File: tb/tb_baby_ram.sv
// Self-checking bench for baby_ram against a word-array reference model.
// Parity checks are built when BABY_RAM_PARITY_EN is defined.
module tb_baby_ram;

    logic clk;
    logic rst;
    logic clear;
    logic busy;
`ifdef BABY_RAM_PARITY_EN
    logic inj;
    logic perr;
`endif

    int n_checks;
    int n_errors;

    logic [31:0] model [32];

    baby_ram_if bus ();

    baby_ram dut (
        .ram_clk_i    (clk),
        .ram_rst_i    (rst),
        .bus          (bus),
`ifdef BABY_RAM_PARITY_EN
        .par_inject_i (inj),
        .par_err_o    (perr),
`endif
        .clear_i      (clear),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Count cycles that busy stays high; called right after it rose.
    task automatic sweep_len(input string tag);
        int n;
        logic [31:0] d0;
        logic held;
        n = 0;
        held = 1'b1;
        d0 = bus.ram_data_o;
        while (busy && n < 100) begin
            tick();
            n++;
            if (bus.ram_data_o !== d0) held = 1'b0;
        end
        chk({tag, "_len"}, 32'(n), 32'd32);
        chk({tag, "_hold"}, 32'(held), 32'd1);
        model_zero();
    endtask

    function automatic logic [31:0] expect_data(input logic w,
                                                input logic [31:0] a,
                                                input logic [31:0] d);
        if (w) return d;
        if (a[31:5] != 0) return 32'h0;
        return model[a[4:0]];
    endfunction

    task automatic model_apply(input logic w, input logic [31:0] a,
                               input logic [31:0] d);
        if (w && a[31:5] == 0) model[a[4:0]] = d;
    endtask

    // One access: assert req, wait for ack, check, then drop req.
    task automatic access(input string tag, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        logic oor;
        logic [31:0] ed;
        logic [31:0] last;
        oor = (a[31:5] != 0);
        ed = expect_data(w, a, d);
        bus.ram_addr_i = a;
        bus.ram_data_i = d;
        bus.we_i = w;
        bus.req_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.ack_o && n < 50);
        chk({tag, "_lat"}, 32'(n), 32'd2);
        if (!(w && oor)) chk({tag, "_data"}, bus.ram_data_o, ed);
        chk({tag, "_err"}, 32'(bus.addr_err_o), 32'(oor));
        bus.req_i = 1'b0;
        model_apply(w, a, d);
        last = bus.ram_data_o;
        tick();
        chk({tag, "_ackpulse"}, 32'(bus.ack_o), 32'd0);
        chk({tag, "_dhold"}, bus.ram_data_o, last);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 31));
        if ($urandom_range(0, 4) == 0)
            a = a | (32'h1 << $urandom_range(5, 31));
        return a;
    endfunction

    initial begin
        int n;
        int busy_fall;
        int ack_at;
        int early;
        int gap;
        logic w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ed;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear = 1'b0;
        bus.req_i = 1'b0;
        bus.we_i = 1'b0;
        bus.ram_addr_i = 32'h0;
        bus.ram_data_i = 32'h0;
`ifdef BABY_RAM_PARITY_EN
        inj = 1'b0;
`endif
        model_zero();

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_err", 32'(bus.addr_err_o), 32'd0);
        chk("rst_data", bus.ram_data_o, 32'h0);
`ifdef BABY_RAM_PARITY_EN
        chk("rst_perr", 32'(perr), 32'd0);
`endif
        rst = 1'b0;
        sweep_len("init_sweep");

        access("rd_1f", 1'b0, 32'h1F, 32'h0);
        access("wr_03", 1'b1, 32'h03, 32'hDEADBEEF);
        access("rd_03", 1'b0, 32'h03, 32'h0);
        access("wr_oor", 1'b1, 32'h23, 32'h12345678);
        access("rd_03b", 1'b0, 32'h03, 32'h0);
        access("rd_oor", 1'b0, 32'h23, 32'h0);

        // Request and clear together: request first, then the sweep.
        access("wr_07", 1'b1, 32'h07, 32'h0);
        clear = 1'b1;
        access("wr_07c", 1'b1, 32'h07, 32'hA5A5A5A5);
        chk("clr_start", 32'(busy), 32'd1);
        clear = 1'b0;
        sweep_len("clr_sweep");
        access("rd_07", 1'b0, 32'h07, 32'h0);

        // Reset mid-sweep with a request held throughout.
        access("wr_09", 1'b1, 32'h09, 32'h13572468);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr2_start", 32'(busy), 32'd1);
        bus.req_i = 1'b1;
        bus.we_i = 1'b0;
        bus.ram_addr_i = 32'h09;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_zero();
        n = 0;
        busy_fall = -1;
        ack_at = -1;
        early = 0;
        while (ack_at < 0 && n < 100) begin
            tick();
            n++;
            if (!busy && busy_fall < 0) busy_fall = n;
            if (bus.ack_o && busy_fall < 0) early++;
            if (bus.ack_o) ack_at = n;
        end
        chk("rstmid_busyfall", 32'(busy_fall), 32'd32);
        chk("rstmid_early", 32'(early), 32'd0);
        chk("rstmid_ackat", 32'(ack_at), 32'd34);
        chk("rstmid_data", bus.ram_data_o, 32'h0);
        bus.req_i = 1'b0;
        tick();

        // Back-to-back accesses with req held high.
        a = rand_addr();
        d = $urandom;
        w = 1'($urandom_range(0, 1));
        bus.ram_addr_i = a;
        bus.ram_data_i = d;
        bus.we_i = w;
        bus.req_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            gap = 0;
            do begin
                tick();
                gap++;
            end while (!bus.ack_o && gap < 50);
            ed = expect_data(w, a, d);
            chk("strm_gap", 32'(gap), 32'd2);
            if (!(w && a[31:5] != 0)) chk("strm_data", bus.ram_data_o, ed);
            chk("strm_err", 32'(bus.addr_err_o), 32'(a[31:5] != 0));
            model_apply(w, a, d);
            a = rand_addr();
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            bus.ram_addr_i = a;
            bus.ram_data_i = d;
            bus.we_i = w;
        end
        bus.req_i = 1'b0;
        tick();

        // Random traffic with occasional sweeps.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                chk("rnd_clr", 32'(busy), 32'd1);
                sweep_len("rnd_sweep");
            end
            access("rnd", 1'($urandom_range(0, 1)), rand_addr(),
                   $urandom);
        end
        for (int i = 0; i < 32; i++) begin
            access("final_rd", 1'b0, 32'(i), 32'h0);
        end

`ifdef BABY_RAM_PARITY_EN
        inj = 1'b1;
        access("par_wr", 1'b1, 32'h05, 32'h1);
        inj = 1'b0;
        chk("par_after_wr", 32'(perr), 32'd0);
        access("par_rd", 1'b0, 32'h05, 32'h0);
        chk("par_set", 32'(perr), 32'd1);
        access("par_rd2", 1'b0, 32'h06, 32'h0);
        chk("par_sticky", 32'(perr), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("par_mid", 32'(perr), 32'd1);
        sweep_len("par_sweep");
        chk("par_clr", 32'(perr), 32'd0);
        access("par_wr2", 1'b1, 32'h05, 32'h7);
        access("par_rd3", 1'b0, 32'h05, 32'h0);
        chk("par_ok", 32'(perr), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
